// File: rtl/acc_pkg.sv
// Shared constants and state encoding for the accumulator sequencer.
package acc_pkg;

  localparam int ACC_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/acc_seq.sv
// Burst sequencer for an external accumulator register: clears it, folds in
// COUNT streamed operands, then publishes the modular sum and a sticky carry.
module acc_seq
  import acc_pkg::*;
#(
  parameter int DATA_W = ACC_W,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  input  logic              op_valid,
  input  logic [DATA_W-1:0] op_data,
  output logic              op_ready,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic              acc_wacc,
  output logic [DATA_W-1:0] acc_in_data,
  input  logic [DATA_W-1:0] acc_out_data
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                carry_q, carry_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W:0]     sum_w;

  // Widened add so the carry-out of every operand accumulation is visible.
  function automatic logic [DATA_W:0] add_carry(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign sum_w = add_carry(acc_out_data, op_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    carry_d  = carry_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = count;
          carry_d = 1'b0;
          state_d = CLEAR;
        end
      end
      CLEAR: state_d = (rem_q != '0) ? ACCUM : DONE;
      ACCUM: begin
        // op_ready is high throughout ACCUM, so op_valid alone marks a transfer.
        if (op_valid) begin
          carry_d = carry_q | sum_w[DATA_W];
          rem_d   = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        result_d = acc_out_data;
        ovf_d    = carry_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    op_ready    = (state_q == ACCUM);
    done        = (state_q == DONE);
    acc_wacc    = (state_q == CLEAR) || ((state_q == ACCUM) && op_valid);
    acc_in_data = (state_q == ACCUM) ? sum_w[DATA_W-1:0] : '0;
  end

  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_acc_seq.sv
// Directed bench for acc_seq with a behavioural model of the acc register.
module tb_acc_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] count;
  logic       busy;
  logic       op_valid;
  logic [7:0] op_data;
  logic       op_ready;
  logic       done;
  logic [7:0] result;
  logic       ovf;
  logic       acc_wacc;
  logic [7:0] acc_in_data;
  logic [7:0] acc_out_data;

  logic [7:0] acc_q = '0;
  logic [7:0] wq[$];

  int checks = 0;
  int errors = 0;

  acc_seq #(.DATA_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .busy(busy),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready), .done(done),
    .result(result), .ovf(ovf), .acc_wacc(acc_wacc), .acc_in_data(acc_in_data),
    .acc_out_data(acc_out_data)
  );

  always #5 clk = ~clk;

  // Model of the external acc register, plus a log of every write.
  always @(posedge clk) begin
    if (acc_wacc) begin
      wq.push_back(acc_in_data);
      acc_q <= acc_in_data;
    end
  end
  assign acc_out_data = acc_q;

  typedef struct {
    int         cnt;
    logic [7:0] ops[4];
    int         gaps[4];
    logic [7:0] res;
    logic       ovf;
    int         lat;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int         cycles;
    int         idx;
    int         gap;
    bit         seen;
    bit         saw_ready;
    logic [7:0] exp_w;
    wq.delete();
    start    = 1'b1;
    count    = v.cnt[3:0];
    op_valid = 1'b0;
    tick();
    start  = 1'b0;
    cycles = 1;
    check("clear_wacc", acc_wacc, 1);
    check("clear_data", acc_in_data, 0);
    check("clear_busy", busy, 1);
    idx = 0;
    gap = v.gaps[0];
    seen = 0;
    saw_ready = 0;
    while (!seen && cycles < 40) begin
      op_valid = 1'b0;
      saw_ready |= op_ready;
      if (op_ready && idx < v.cnt) begin
        if (gap > 0) begin
          gap--;
        end else begin
          op_valid = 1'b1;
          op_data  = v.ops[idx];
          idx++;
          gap = (idx < 4) ? v.gaps[idx] : 0;
        end
      end
      #1;
      if (op_ready && !op_valid) check("stall_wacc", acc_wacc, 0);
      tick();
      cycles++;
      if (done) seen = 1;
    end
    op_valid = 1'b0;
    check("done_seen", seen, 1);
    check("latency", cycles, v.lat);
    if (v.cnt == 0) check("zero_no_ready", saw_ready, 0);
    tick();
    check("done_width", done, 0);
    check("idle_busy", busy, 0);
    check("result", result, v.res);
    check("ovf", ovf, v.ovf);
    check("write_count", wq.size(), v.cnt + 1);
    exp_w = 8'd0;
    if (wq.size() == v.cnt + 1) begin
      check("write_0", wq[0], exp_w);
      for (int i = 0; i < v.cnt; i++) begin
        exp_w = exp_w + v.ops[i];
        check("write_n", wq[i+1], exp_w);
      end
    end
  endtask

  initial begin
    vecs[0] = '{3, '{8'd10, 8'd20, 8'd30, 8'd0}, '{0, 0, 0, 0}, 8'd60, 1'b0, 5};
    vecs[1] = '{2, '{8'd200, 8'd100, 8'd0, 8'd0}, '{0, 0, 0, 0}, 8'd44, 1'b1, 4};
    vecs[2] = '{2, '{8'd7, 8'd9, 8'd0, 8'd0}, '{0, 3, 0, 0}, 8'd16, 1'b0, 7};
    vecs[3] = '{0, '{8'd0, 8'd0, 8'd0, 8'd0}, '{0, 0, 0, 0}, 8'd0, 1'b0, 2};
    vecs[4] = '{4, '{8'd255, 8'd1, 8'd0, 8'd0}, '{1, 0, 2, 0}, 8'd0, 1'b1, 9};
    vecs[5] = '{1, '{8'd5, 8'd0, 8'd0, 8'd0}, '{0, 0, 0, 0}, 8'd5, 1'b0, 3};

    rst = 1'b1; start = 1'b0; count = '0; op_valid = 1'b0; op_data = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_ready", op_ready, 0);
    check("rst_done", done, 0);
    check("rst_wacc", acc_wacc, 0);
    check("rst_data", acc_in_data, 0);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a burst.
    start = 1'b1; count = 4'd4;
    tick();
    start = 1'b0;
    tick();
    op_valid = 1'b1; op_data = 8'd1;
    tick();
    op_data = 8'd2;
    tick();
    op_data = 8'd3;
    #2;
    check("pre_rst_wacc", acc_wacc, 1);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", op_ready, 0);
    check("arst_wacc", acc_wacc, 0);
    check("arst_result", result, 0);
    #2;
    rst = 1'b0;
    op_valid = 1'b0;
    tick();
    check("post_rst_idle", busy, 0);
    run_vec(vecs[5]);

    // start is ignored during ACCUM and during DONE.
    start = 1'b1; count = 4'd2;
    tick();
    start = 1'b0;
    tick();
    op_valid = 1'b1; op_data = 8'd3;
    start = 1'b1; count = 4'd9;
    tick();
    start = 1'b0;
    op_data = 8'd4;
    tick();
    op_valid = 1'b0;
    check("busy_start_done", done, 1);
    start = 1'b1; count = 4'd1;
    tick();
    start = 1'b0;
    check("done_start_ignored", busy, 0);
    check("busy_start_result", result, 7);
    tick();
    check("still_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
